// File: rtl/adder_chk_pkg.sv
// rtl/adder_chk_pkg.sv - Shared state encoding and counter sizing for the adder result checker.
package adder_chk_pkg;

   typedef enum logic [2:0] {
      IDLE,
      DRIVE,
      SETTLE,
      CHECK,
      DONE
   } state_t;

   // Counters hold up to 2^(2*SIZE+1) without wrapping.
   function automatic int cnt_width(input int size);
      return 2 * size + 2;
   endfunction

endpackage

// File: rtl/adder_result_checker_if.sv
// rtl/adder_result_checker_if.sv - Operand/result bus between the checker and the adder under check.
interface adder_result_checker_if #(
   parameter int SIZE = 4
);
   logic [SIZE-1:0] a_out;
   logic [SIZE-1:0] b_out;
   logic            cin_out;
   logic [SIZE-1:0] s_in;
   logic            cout_in;

   modport master (
      output a_out, b_out, cin_out,
      input  s_in, cout_in
   );

   modport slave (
      input  a_out, b_out, cin_out,
      output s_in, cout_in
   );
endinterface

// File: rtl/settle_timer.sv
// rtl/settle_timer.sv - Down-counter that flags the last cycle of the settle window.
module settle_timer (
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic       enable,
   input  logic [7:0] count_value,
   output logic       expired
);
   logic [7:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= 8'd0;
      end else if (load) begin
         cnt <= count_value;
      end else if (enable && cnt != 8'd0) begin
         cnt <= cnt - 8'd1;
      end
   end

   // High during the final settle cycle, so the window lasts exactly count_value cycles.
   assign expired = (cnt <= 8'd1);
endmodule

// File: rtl/adder_result_checker.sv
// rtl/adder_result_checker.sv - Exhaustive sweep of an external adder against an internal reference sum.
module adder_result_checker
   import adder_chk_pkg::*;
#(
   parameter int SIZE          = 4,
   parameter int SETTLE_CYCLES = 3
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   adder_result_checker_if.master     bus,
   output logic                       busy,
   output logic                       done,
   output logic                       pass,
   output logic [cnt_width(SIZE)-1:0] err_count,
   output logic [cnt_width(SIZE)-1:0] vec_count,
   output logic [2*SIZE:0]            fail_vec
);
   localparam int CW = cnt_width(SIZE);
   localparam int IW = 2 * SIZE + 1;

   state_t          state;
   logic [IW-1:0]   idx;
   logic [SIZE:0]   ref_sum;
   logic            mismatch;
   logic            expired;

   settle_timer u_settle_timer (
      .clk         (clk),
      .rst         (rst),
      .load        (state == DRIVE),
      .enable      (state == SETTLE),
      .count_value (8'(SETTLE_CYCLES)),
      .expired     (expired)
   );

   always_comb begin
      ref_sum  = {1'b0, bus.a_out} + {1'b0, bus.b_out} + {{SIZE{1'b0}}, bus.cin_out};
      mismatch = ({bus.cout_in, bus.s_in} != ref_sum);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         idx         <= '0;
         bus.a_out   <= '0;
         bus.b_out   <= '0;
         bus.cin_out <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         pass        <= 1'b0;
         err_count   <= '0;
         vec_count   <= '0;
         fail_vec    <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  idx       <= '0;
                  err_count <= '0;
                  vec_count <= '0;
                  fail_vec  <= '0;
                  busy      <= 1'b1;
                  done      <= 1'b0;
                  pass      <= 1'b0;
                  state     <= DRIVE;
               end
            end
            DRIVE: begin
               bus.a_out   <= idx[SIZE-1:0];
               bus.b_out   <= idx[2*SIZE-1:SIZE];
               bus.cin_out <= idx[2*SIZE];
               state       <= SETTLE;
            end
            SETTLE: begin
               if (expired) state <= CHECK;
            end
            CHECK: begin
               vec_count <= vec_count + CW'(1);
               if (mismatch) begin
                  err_count <= err_count + CW'(1);
                  if (err_count == '0) fail_vec <= idx;
               end
               if (idx == '1) begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  pass  <= (err_count == '0) && !mismatch;
                  state <= DONE;
               end else begin
                  idx   <= idx + IW'(1);
                  state <= DRIVE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_adder_result_checker.sv
// tb/tb_adder_result_checker.sv - Scoreboard bench sweeping correct and faulty adder models.
module tb_adder_result_checker;
   localparam int SIZE = 4;
   localparam int SC   = 3;

   typedef struct {
      int         vecs;
      int         errs;
      logic       pass;
      logic [8:0] fv;
   } res_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       busy, done, pass;
   logic [9:0] err_count, vec_count;
   logic [8:0] fail_vec;
   int         mode;
   int         compared   = 0;
   int         mismatched = 0;

   res_t       res_q[$];
   logic [8:0] op_q[$];

   always #5 clk = ~clk;

   adder_result_checker_if #(.SIZE(SIZE)) bus ();

   adder_result_checker #(.SIZE(SIZE), .SETTLE_CYCLES(SC)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .bus       (bus),
      .busy      (busy),
      .done      (done),
      .pass      (pass),
      .err_count (err_count),
      .vec_count (vec_count),
      .fail_vec  (fail_vec)
   );

   // Adder under check: 0 correct, 1 cout stuck at 0, 2 s[0] flipped only for a=7,b=0,cin=1.
   function automatic logic [4:0] adder_model(input int m, input logic [3:0] a, input logic [3:0] b, input logic c);
      logic [4:0] t;
      t = {1'b0, a} + {1'b0, b} + {4'b0, c};
      if (m == 1) t[4] = 1'b0;
      if (m == 2 && a == 4'd7 && b == 4'd0 && c == 1'b1) t[0] = ~t[0];
      return t;
   endfunction

   always_comb begin
      logic [4:0] r;
      r           = adder_model(mode, bus.a_out, bus.b_out, bus.cin_out);
      bus.s_in    = r[3:0];
      bus.cout_in = r[4];
   end

   task automatic push_expected(input int m);
      res_t r;
      r.vecs = 0; r.errs = 0; r.fv = 9'd0;
      for (int v = 0; v < 512; v++) begin
         logic [8:0] vv;
         logic [4:0] truth;
         vv    = 9'(v);
         truth = {1'b0, vv[3:0]} + {1'b0, vv[7:4]} + {4'b0, vv[8]};
         op_q.push_back(vv);
         r.vecs++;
         if (adder_model(m, vv[3:0], vv[7:4], vv[8]) != truth) begin
            if (r.errs == 0) r.fv = vv;
            r.errs++;
         end
      end
      r.pass = (r.errs == 0);
      res_q.push_back(r);
   endtask

   task automatic run_sweep(input int m, input bit poke);
      int   e;
      bit   seen;
      res_t r;
      mode = m;
      push_expected(m);
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      compared++;
      if (vec_count !== 10'd0 || err_count !== 10'd0 || busy !== 1'b1) begin
         mismatched++;
         $display("FAIL start_clear vec=%0d err=%0d busy=%b want 0 0 1", vec_count, err_count, busy);
      end
      e = 0; seen = 0;
      while (!seen && e < 3000) begin
         @(posedge clk);
         e++;
         @(negedge clk);
         if (poke && e == 3) start = 1'b1;
         if (poke && e == 4) start = 1'b0;
         if (e % 5 == 2 && op_q.size() > 0) begin
            logic [8:0] exp_op;
            exp_op = op_q.pop_front();
            compared++;
            if ({bus.cin_out, bus.b_out, bus.a_out} !== exp_op) begin
               mismatched++;
               $display("FAIL operands edge=%0d got %h want %h", e, {bus.cin_out, bus.b_out, bus.a_out}, exp_op);
            end
         end
         if (done) seen = 1;
      end
      compared++;
      if (e != 2560) begin
         mismatched++;
         $display("FAIL done_latency got %0d edges want 2560", e);
      end
      op_q.delete();
      r = res_q.pop_front();
      compared++;
      if (vec_count !== 10'(r.vecs) || err_count !== 10'(r.errs) || pass !== r.pass ||
          fail_vec !== r.fv || busy !== 1'b0) begin
         mismatched++;
         $display("FAIL result vec=%0d err=%0d pass=%b fv=%b busy=%b want %0d %0d %b %b 0",
                  vec_count, err_count, pass, fail_vec, busy, r.vecs, r.errs, r.pass, r.fv);
      end
   endtask

   task automatic check_all_zero(input string name);
      compared++;
      if ({bus.a_out, bus.b_out, bus.cin_out, busy, done, pass, err_count, vec_count, fail_vec} !== '0) begin
         mismatched++;
         $display("FAIL %s a=%h b=%h cin=%b busy=%b done=%b pass=%b err=%0d vec=%0d fv=%h want all 0",
                  name, bus.a_out, bus.b_out, bus.cin_out, busy, done, pass, err_count, vec_count, fail_vec);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; mode = 0;
      #12;
      check_all_zero("reset_state");
      @(negedge clk) rst = 1'b0;
      repeat (5) @(negedge clk);
      check_all_zero("idle_after_reset");
   endtask

   task automatic test_correct();
      run_sweep(0, 1'b0);
      repeat (10) @(negedge clk);
      compared++;
      if (done !== 1'b1 || vec_count !== 10'd512 || {bus.cin_out, bus.b_out, bus.a_out} !== 9'h1ff) begin
         mismatched++;
         $display("FAIL done_hold done=%b vec=%0d ops=%h want 1 512 1ff", done, vec_count,
                  {bus.cin_out, bus.b_out, bus.a_out});
      end
   endtask

   task automatic test_cout_stuck();
      run_sweep(1, 1'b0);
   endtask

   task automatic test_restart();
      run_sweep(0, 1'b0);
   endtask

   task automatic test_start_ignored();
      run_sweep(0, 1'b1);
   endtask

   task automatic test_single_bit();
      run_sweep(2, 1'b0);
   endtask

   task automatic test_reset_mid();
      int n;
      mode = 0;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      n = 0;
      while (vec_count != 10'd100 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      compared++;
      if (vec_count !== 10'd100) begin
         mismatched++;
         $display("FAIL reach_vec100 got %0d want 100", vec_count);
      end
      #2 rst = 1'b1;
      #1;
      check_all_zero("async_reset");
      @(negedge clk) rst = 1'b0;
      repeat (20) @(negedge clk);
      check_all_zero("stay_idle");
   endtask

   initial begin
      test_reset();
      test_correct();
      test_cout_stuck();
      test_restart();
      test_start_ignored();
      test_single_bit();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule

// File: doc/adder_result_checker.md
ADDER_RESULT_CHECKER -- requirements
Module: adder_result_checker

Interface
REQ-001 The module SHALL have parameter SIZE, default 4, giving the operand width of the adder under check.
REQ-002 The module SHALL have parameter SETTLE_CYCLES, default 3, giving the number of clock cycles allowed for the adder outputs to settle; legal range is 1 to 255.
REQ-003 The module SHALL have one clock and an asynchronous, active-high reset.
REQ-004 Port clk, input, 1: rising-edge clock.
REQ-005 Port rst, input, 1: asynchronous, active-high reset.
REQ-006 Port start, input, 1: requests an exhaustive sweep; it is sampled only in IDLE or DONE.
REQ-007 Ports a_out and b_out, outputs, SIZE each: operands driven to the adder.
REQ-008 Port cin_out, output, 1: carry-in driven to the adder.
REQ-009 Port s_in, input, SIZE: sum returned by the adder.
REQ-010 Port cout_in, input, 1: carry-out returned by the adder.
REQ-011 Port busy, output, 1: high in DRIVE, SETTLE and CHECK.
REQ-012 Port done, output, 1: high in DONE.
REQ-013 Port pass, output, 1: high in DONE when err_count equals 0.
REQ-014 Ports err_count and vec_count, outputs, 2*SIZE+2 each: mismatch count and checked-vector count.
REQ-015 Port fail_vec, output, 2*SIZE+1: the {cin,b,a} index of the first mismatching vector.

Function
REQ-016 The state machine SHALL have the states IDLE, DRIVE, SETTLE, CHECK and DONE.
REQ-017 In IDLE or DONE, start=1 SHALL clear idx, err_count, vec_count and fail_vec, and SHALL move the state to DRIVE.
REQ-018 While busy=1, start SHALL be ignored.
REQ-019 DRIVE SHALL register a_out=idx[SIZE-1:0], b_out=idx[2*SIZE-1:SIZE] and cin_out=idx[2*SIZE], load the settle counter with SETTLE_CYCLES, and move to SETTLE.
REQ-020 SETTLE SHALL decrement the settle counter once per cycle and SHALL move to CHECK after exactly SETTLE_CYCLES cycles.
REQ-021 CHECK SHALL compare {cout_in,s_in} against a_out+b_out+cin_out, computed at SIZE+1 bits with no truncation.
REQ-022 On a mismatch, CHECK SHALL increment err_count, and SHALL load fail_vec with idx only when err_count was 0 before the increment.
REQ-023 CHECK SHALL increment vec_count on every vector.
REQ-024 CHECK SHALL move to DONE when idx is all ones; otherwise it SHALL increment idx and move to DRIVE.
REQ-025 Each vector SHALL take SETTLE_CYCLES+2 cycles, and the full sweep SHALL cover 2^(2*SIZE+1) vectors.
REQ-026 Operand outputs SHALL hold their values from DRIVE through CHECK.
REQ-027 In DONE, all outputs SHALL be held until a restart or reset.
REQ-028 Counters SHALL be sized so they never wrap; vec_count SHALL end at exactly 2^(2*SIZE+1).

Reset
REQ-029 Asserting rst in any state, including mid-sweep, SHALL immediately force IDLE and zero every output: a_out, b_out, cin_out, busy, done, pass, err_count, vec_count and fail_vec.
REQ-030 After rst is released, the next action SHALL occur only on a start pulse.

Structure
REQ-031 The package adder_chk_pkg SHALL hold the state enumeration and a width function for counters of 2*SIZE+2 bits.
REQ-032 The settle down-counter SHALL be a separate sub-module named settle_timer, with inputs load and count_value and output expired.
REQ-033 The reference sum SHALL be computed inside the checker, independent of the adder under check.

Verification
REQ-034 Correct 4-bit adder, SETTLE_CYCLES=3, one start pulse: done SHALL rise 2560 edges after the edge that samples start; vec_count=512, err_count=0, pass=1.
REQ-035 Adder with cout stuck at 0: err_count SHALL be 256, pass=0, and fail_vec SHALL be 9'b0_0001_1111 (a=15, b=1, cin=0).
REQ-036 Assert rst while vec_count=100: all outputs SHALL go to 0 without waiting for a clock edge, and the state SHALL remain IDLE until start.
REQ-037 Pulse start during SETTLE: there SHALL be no restart, and the final counts SHALL match REQ-034.
REQ-038 Run the REQ-035 sweep, then pulse start with a correct adder: counters SHALL clear and the sweep SHALL end with err_count=0, pass=1 and fail_vec=0.
REQ-039 Adder with s[0] inverted only when a=7, b=0, cin=1: err_count SHALL be 1 and fail_vec SHALL be 9'b1_0000_0111.
